// File: rtl/ibert_param_stream_seq.sv
// rtl/ibert_param_stream_seq.sv - sequences per-channel parameter phases into one tagged output stream
module ibert_param_stream_seq #(
    parameter int D_W    = 32,
    parameter int NCH    = 5,
    parameter int LEN_W  = 24,
    parameter int ITER_W = 8,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ITER_W-1:0]    iters,
    input  logic [NCH*LEN_W-1:0] lens,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*D_W-1:0]   in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [D_W-1:0]       out_data,
    output logic                 out_last,
    output logic [CH_W-1:0]      out_ch,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done,
    output logic [ITER_W-1:0]    cur_iter
);

    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_STREAM, S_DRAIN, S_FIN} state_t;

    state_t               state, state_next;
    logic [NCH*LEN_W-1:0] lens_q;
    logic [ITER_W-1:0]    iters_q, iter_next, iter_inc;
    logic [CH_W-1:0]      ch, ch_next, ch_adv;
    logic [LEN_W-1:0]     cnt, cnt_next, cur_len;
    logic                 ch_wrap, round_done, latch, push, pop;
    logic [D_W-1:0]       push_data;

    logic [D_W-1:0]       fifo_data [2];
    logic [CH_W-1:0]      fifo_ch   [2];
    logic                 fifo_last [2];
    logic                 wr_ptr, rd_ptr;
    logic [1:0]           count;

    assign cur_len    = lens_q[ch*LEN_W +: LEN_W];
    assign ch_wrap    = (ch == CH_W'(NCH - 1));
    assign iter_inc   = cur_iter + 1'b1;
    assign ch_adv     = ch_wrap ? '0 : ch + 1'b1;
    assign round_done = ch_wrap && (iter_inc == iters_q);

    // Ready depends only on local state and occupancy, never on out_ready.
    assign in_ready  = (state == S_STREAM && count < 2'd2) ? (NCH'(1) << ch) : '0;
    assign push      = in_valid[ch] && in_ready[ch];
    assign push_data = in_data[ch*D_W +: D_W];
    assign pop       = out_valid && out_ready;

    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_ch    = fifo_ch[rd_ptr];
    assign out_last  = fifo_last[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN) && !abort;

    always_comb begin
        state_next = state;
        ch_next    = ch;
        cnt_next   = cnt;
        iter_next  = cur_iter;
        latch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch      = 1'b1;
                    ch_next    = '0;
                    iter_next  = '0;
                    state_next = (iters == '0) ? S_FIN : S_SELECT;
                end
            end
            S_SELECT: begin
                if (cur_len == '0) begin
                    ch_next    = ch_adv;
                    iter_next  = ch_wrap ? iter_inc : cur_iter;
                    state_next = round_done ? S_DRAIN : S_SELECT;
                end else begin
                    cnt_next   = cur_len;
                    state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (push) begin
                    cnt_next = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        ch_next    = ch_adv;
                        iter_next  = ch_wrap ? iter_inc : cur_iter;
                        state_next = round_done ? S_DRAIN : S_SELECT;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the last buffered beat is taken so done follows it by one cycle.
                if (count == 2'd0 || (count == 2'd1 && pop))
                    state_next = S_FIN;
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) begin
            state_next = S_IDLE;
            ch_next    = '0;
            cnt_next   = '0;
            iter_next  = '0;
            latch      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            lens_q   <= '0;
            iters_q  <= '0;
            ch       <= '0;
            cnt      <= '0;
            cur_iter <= '0;
        end else begin
            state    <= state_next;
            ch       <= ch_next;
            cnt      <= cnt_next;
            cur_iter <= iter_next;
            if (latch) begin
                lens_q  <= lens;
                iters_q <= iters;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_ch[i]   <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else if (abort) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= push_data;
                fifo_ch[wr_ptr]   <= ch;
                fifo_last[wr_ptr] <= (cnt == LEN_W'(1));
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ibert_param_stream_seq.sv
// tb/tb_ibert_param_stream_seq.sv - randomized self-checking bench for ibert_param_stream_seq
module tb_ibert_param_stream_seq;

    localparam int D_W = 32, NCH = 5, LEN_W = 24, ITER_W = 8, CH_W = 3;

    logic                 clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [ITER_W-1:0]    iters = '0;
    logic [NCH*LEN_W-1:0] lens = '0;
    logic [NCH-1:0]       in_valid = '1;
    logic [NCH-1:0]       in_ready;
    logic [NCH*D_W-1:0]   in_data;
    logic                 out_valid, out_last, busy, done;
    logic [D_W-1:0]       out_data;
    logic [CH_W-1:0]      out_ch;
    logic [ITER_W-1:0]    cur_iter;

    always #5 clk = ~clk;

    ibert_param_stream_seq #(.D_W(D_W), .NCH(NCH), .LEN_W(LEN_W), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iters(iters), .lens(lens),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_ready(out_ready), .busy(busy), .done(done), .cur_iter(cur_iter)
    );

    typedef struct packed {
        logic [D_W-1:0]    data;
        logic [CH_W-1:0]   ch;
        logic              last;
        logic [ITER_W-1:0] iter;
    } beat_t;

    beat_t             exp_q[$], got_q[$];
    logic [ITER_W-1:0] acc_iter_q[$];
    logic [D_W-1:0]    data_tab [NCH][1024];
    int                idx [NCH];
    int                cur_lens [NCH];
    int                cur_iters;
    int                checks = 0, errors = 0;
    int                cyc = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, last_beat_cyc = 0, stall_bad = 0;
    bit                rand_ready = 0, rand_valid = 0;
    logic              prev_stall = 1'b0;
    beat_t             prev_head;

    // Each source walks its own table; the index advances only on an accepted beat.
    for (genvar c = 0; c < NCH; c++) begin : g_src
        assign in_data[c*D_W +: D_W] = data_tab[c][idx[c]];
    end

    task automatic tick();
        logic [NCH-1:0] acc;
        @(negedge clk);
        cyc++;
        acc = in_valid & in_ready;
        if (acc != '0) acc_iter_q.push_back(cur_iter);
        if (prev_stall && (!out_valid || out_data !== prev_head.data || out_ch !== prev_head.ch || out_last !== prev_head.last))
            stall_bad++;
        prev_stall = out_valid && !out_ready;
        prev_head  = '{data: out_data, ch: out_ch, last: out_last, iter: cur_iter};
        if (out_valid && out_ready) begin
            got_q.push_back('{data: out_data, ch: out_ch, last: out_last, iter: cur_iter});
            last_beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) if (acc[c]) idx[c]++;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        in_valid  = rand_valid ? NCH'($urandom) : '1;
    endtask

    // Reference stream: rounds of channels in order, each channel emitting len beats of its next table entries.
    task automatic build_expected();
        int k [NCH];
        exp_q.delete();
        for (int c = 0; c < NCH; c++) k[c] = idx[c];
        for (int r = 0; r < cur_iters; r++)
            for (int c = 0; c < NCH; c++)
                for (int b = 0; b < cur_lens[c]; b++) begin
                    exp_q.push_back('{data: data_tab[c][k[c]], ch: CH_W'(c), last: (b == cur_lens[c] - 1), iter: ITER_W'(r)});
                    k[c]++;
                end
    endtask

    task automatic start_seq();
        got_q.delete();
        acc_iter_q.delete();
        done_cnt  = 0;
        stall_bad = 0;
        for (int c = 0; c < NCH; c++) lens[c*LEN_W +: LEN_W] = LEN_W'(cur_lens[c]);
        iters = ITER_W'(cur_iters);
        build_expected();
        start = 1'b1;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        timed_out = (done_cnt == 0);
        repeat (3) tick();
    endtask

    task automatic set_basic();
        cur_lens  = '{3, 1, 1, 0, 4};
        cur_iters = 1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0 || out_ch !== '0) begin errors++; $display("FAIL reset_last_ch got %b/%0d want 0/0", out_last, out_ch); end
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cur_iter !== '0) begin errors++; $display("FAIL reset_status got busy=%b done=%b iter=%0d want 0/0/0", busy, done, cur_iter); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        set_basic();
        start_seq();
        wait_done(100, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
        checks++; if (got_q.size() != 9) begin errors++; $display("FAIL basic_count got %0d want 9", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].ch !== exp_q[i].ch || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL basic_beat%0d got %h/%0d/%b want %h/%0d/%b", i, got_q[i].data, got_q[i].ch, got_q[i].last, exp_q[i].data, exp_q[i].ch, exp_q[i].last);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
        checks++; if (done_cyc - last_beat_cyc != 1) begin errors++; $display("FAIL basic_done_latency got %0d want 1", done_cyc - last_beat_cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_iters2();
        bit to;
        set_basic();
        cur_iters = 2;
        start_seq();
        wait_done(200, to);
        checks++; if (to) begin errors++; $display("FAIL iters2_timeout got no done want done"); end
        checks++; if (got_q.size() != 18) begin errors++; $display("FAIL iters2_count got %0d want 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].ch !== exp_q[i].ch || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL iters2_beat%0d got %h/%0d/%b want %h/%0d/%b", i, got_q[i].data, got_q[i].ch, got_q[i].last, exp_q[i].data, exp_q[i].ch, exp_q[i].last);
            end
        end
        for (int i = 0; i < acc_iter_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (acc_iter_q[i] !== exp_q[i].iter) begin
                errors++;
                $display("FAIL iters2_cur_iter%0d got %0d want %0d", i, acc_iter_q[i], exp_q[i].iter);
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL iters2_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_random_ready();
        bit to;
        rand_ready = 1;
        rand_valid = 1;
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < NCH; c++) cur_lens[c] = $urandom_range(0, 4);
            cur_iters = $urandom_range(1, 3);
            start_seq();
            wait_done(2000, to);
            checks++; if (to) begin errors++; $display("FAIL rand%0d_timeout got no done want done", t); end
            checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d", t, got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i].data !== exp_q[i].data || got_q[i].ch !== exp_q[i].ch || got_q[i].last !== exp_q[i].last) begin
                    errors++;
                    $display("FAIL rand%0d_beat%0d got %h/%0d/%b want %h/%0d/%b", t, i, got_q[i].data, got_q[i].ch, got_q[i].last, exp_q[i].data, exp_q[i].ch, exp_q[i].last);
                end
            end
            checks++; if (stall_bad != 0) begin errors++; $display("FAIL rand%0d_stall_stable got %0d changes want 0", t, stall_bad); end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_count got %0d want 1", t, done_cnt); end
        end
        rand_ready = 0;
        rand_valid = 0;
        repeat (2) tick();
    endtask

    task automatic test_zero();
        bit to;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                set_basic();
                cur_iters = 0;
            end else begin
                cur_lens  = '{0, 0, 0, 0, 0};
                cur_iters = 1;
            end
            start_seq();
            wait_done(50, to);
            checks++; if (to) begin errors++; $display("FAIL zero%0d_timeout got no done want done", t); end
            checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero%0d_count got %0d want 0", t, got_q.size()); end
            checks++;
            if (done_cyc - start_cyc < 1 || done_cyc - start_cyc > NCH + 3) begin
                errors++;
                $display("FAIL zero%0d_done_latency got %0d want 1..%0d", t, done_cyc - start_cyc, NCH + 3);
            end
            checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero%0d_done_count got %0d want 1", t, done_cnt); end
        end
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        set_basic();
        start_seq();
        while (got_q.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        checks++; if (got_q.size() < 2) begin errors++; $display("FAIL abort_setup got %0d beats want 2", got_q.size()); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0 || in_ready !== '0) begin errors++; $display("FAIL abort_busy_ready got %b/%b want 0/0", busy, in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_now got %b want 0", done); end
        done_cnt = 0;
        repeat (10) tick();
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
        set_basic();
        start_seq();
        wait_done(100, to);
        checks++; if (to || got_q.size() != 9) begin errors++; $display("FAIL abort_restart_count got %0d timeout=%b want 9", got_q.size(), to); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].ch !== exp_q[i].ch || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL abort_restart_beat%0d got %h/%0d/%b want %h/%0d/%b", i, got_q[i].data, got_q[i].ch, got_q[i].last, exp_q[i].data, exp_q[i].ch, exp_q[i].last);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0, seen;
        set_basic();
        start_seq();
        while (got_q.size() < 3 && n < 50) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || out_ch !== '0) begin errors++; $display("FAIL rstmid_out got %b/%h/%b/%0d want 0", out_valid, out_data, out_last, out_ch); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cur_iter !== '0 || in_ready !== '0) begin errors++; $display("FAIL rstmid_status got %b/%b/%0d/%b want 0", busy, done, cur_iter, in_ready); end
        repeat (2) tick();
        rst = 1'b1;
        seen = got_q.size();
        repeat (5) tick();
        checks++; if (busy !== 1'b0 || got_q.size() != seen) begin errors++; $display("FAIL rstmid_idle got busy=%b beats=%0d want 0/%0d", busy, got_q.size(), seen); end
        start_seq();
        wait_done(100, to);
        checks++; if (to || got_q.size() != 9) begin errors++; $display("FAIL rstmid_restart_count got %0d timeout=%b want 9", got_q.size(), to); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i].data !== exp_q[i].data || got_q[i].ch !== exp_q[i].ch || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %h/%0d/%b want %h/%0d/%b", i, got_q[i].data, got_q[i].ch, got_q[i].last, exp_q[i].data, exp_q[i].ch, exp_q[i].last);
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            idx[c] = 0;
            for (int k = 0; k < 1024; k++) data_tab[c][k] = $urandom;
        end
        test_reset();
        test_basic();
        test_iters2();
        test_random_ready();
        test_zero();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibert_param_stream_seq.md
IBERT_PARAM_STREAM_SEQ -- requirements
Module: ibert_param_stream_seq

Interface
REQ-001 SHALL have parameter D_W, default 32: stream data width.
REQ-002 SHALL have parameter NCH, default 5: number of input channels (bias, out_m, out_e, W, spare), range 1..8.
REQ-003 SHALL have parameter LEN_W, default 24: phase-length width in beats.
REQ-004 SHALL have parameter ITER_W, default 8: iteration-count width (REUSE*SLICES).
REQ-005 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  a one-cycle request to begin a sequence.
REQ-008 SHALL have port abort  in  1  synchronous flush back to idle.
REQ-009 SHALL have port iters  in  ITER_W  the number of full channel rounds.
REQ-010 SHALL have port lens  in  NCH*LEN_W  the per-channel phase length in beats, with channel c at bits [c*LEN_W +: LEN_W].
REQ-011 SHALL have port in_valid  in  NCH  the per-channel source valid.
REQ-012 SHALL have port in_data  in  NCH*D_W  the per-channel source data, signed.
REQ-013 SHALL have port in_ready  out  NCH  the per-channel source ready.
REQ-014 SHALL have port out_valid / out_data[D_W] / out_last / out_ch[max(1,clog2 NCH)]  out  the merged stream, its last-of-phase flag, and its channel tag.
REQ-015 SHALL have port out_ready  in  1  the downstream ready.
REQ-016 SHALL have port busy  out  1  high from start acceptance until done or abort.
REQ-017 SHALL have port done  out  1  a one-cycle completion pulse.
REQ-018 SHALL have port cur_iter  out  ITER_W  the index of the current iteration.

Function
REQ-019 SHALL implement FSM states IDLE, SELECT, STREAM, DRAIN, FIN.
REQ-020 SHALL, in IDLE, accept start by latching lens and iters, setting ch=0 and cur_iter=0, and going to SELECT; start outside IDLE SHALL be ignored.
REQ-021 SHALL, on start with iters==0, go directly to FIN with no output beats.
REQ-022 SHALL, in SELECT with len[ch]==0, skip the channel at one cycle per channel; otherwise it SHALL load beat counter=len[ch] and go to STREAM.
REQ-023 SHALL drive in_ready[c]=1 only when state==STREAM, c==ch, and buffer occupancy<2; this SHALL have no combinational path from out_ready.
REQ-024 SHALL count an input beat when in_valid[ch]&&in_ready[ch]; each beat SHALL push {data, ch, last} into a 2-entry FIFO, with last=1 on the final beat of the phase.
REQ-025 SHALL, after the final beat of a phase, advance ch; if ch wraps past NCH-1 it SHALL increment cur_iter; if cur_iter reaches iters it SHALL go to DRAIN, else it SHALL go to SELECT (one-cycle bubble per phase).
REQ-026 SHALL drive out_valid from the FIFO head (registered); a pop SHALL occur on out_valid&&out_ready; a push and pop in the same cycle SHALL leave occupancy unchanged, sustaining 1 beat/cycle.
REQ-027 SHALL give an input beat accepted at cycle k out_valid no earlier than k+1.
REQ-028 SHALL hold out_data/out_last/out_ch stable while out_valid&&!out_ready.
REQ-029 SHALL, in DRAIN, wait for FIFO empty, then go to FIN; FIN SHALL pulse done=1 for one cycle and return to IDLE with busy=0.
REQ-030 SHALL, on abort in any state, return to IDLE next cycle, clear the FIFO and counters, and drive in_ready=0, out_valid=0, with no done pulse; abort SHALL win over a simultaneous start.
REQ-031 SHALL treat all rounds as identical for iters>1, using the lens latched at start.
REQ-032 SHALL drive in_ready=0 for channels that are not selected, regardless of their in_valid.

Reset
REQ-033 SHALL, while rst==0, asynchronously force state=IDLE, FIFO empty, in_ready=0, out_valid=0, out_last=0, out_data=0, out_ch=0, busy=0, done=0, cur_iter=0.
REQ-034 SHALL make reset mid-sequence discard all buffered beats; after release the block SHALL require a new start.

Verification
REQ-035 SHALL cover: NCH=5, lens={3,1,1,0,4}, iters=1, all sources valid, out_ready=1 -> 9 beats in order ch0x3, ch1, ch2, ch4x4, with out_last on beats 3, 4, 5, 9, and done one cycle after beat 9.
REQ-036 SHALL cover: iters=2, same lens -> 18 beats, cur_iter 0 then 1, a single done pulse.
REQ-037 SHALL cover: out_ready toggled randomly at 50% -> data order is unchanged, no beat is lost or duplicated, and outputs are stable while stalled.
REQ-038 SHALL cover: iters=0, or all lens=0 with iters=1 -> zero output beats and done within NCH+3 cycles.
REQ-039 SHALL cover: abort asserted after beat 2 of ch0 -> out_valid=0 and busy=0 next cycle, no done, and a fresh start reproduces the REQ-035 stream.
REQ-040 SHALL cover: rst pulled low mid-STREAM -> all outputs at reset values immediately, and a later start operates normally.
